// File: rtl/instr_mem_ctrl.sv
// Instruction memory with program-load port and valid/ready fetch path.
// Optional bounds check on upper pc bits: define IMEM_BOUNDS_CHK_EN.
module instr_mem_ctrl #(
  parameter  int N     = 32,
  parameter  int DEPTH = 64,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [N-1:0]  ld_data,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [N-1:0]  pc,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [N-1:0]  instruction,
  output logic          fault
);

  typedef enum logic {
    IDLE = 1'b0,
    RESP = 1'b1
  } state_e;

  state_e           state_q, state_d;
  logic [N-1:0]     mem_q [DEPTH];
  logic [DEPTH-1:0] bitmap_q, bitmap_d;
  logic [N-1:0]     instr_q, instr_d;
  logic             fault_q, fault_d;

  logic [AW-1:0]    idx;
  logic             accept;
  logic             rd_fault;
  logic [N-1:0]     rd_word;
  logic             unused_pc;

  assign idx       = pc[AW+1:2];
  assign unused_pc = ^pc[1:0];

`ifdef IMEM_BOUNDS_CHK_EN
  assign rd_fault = |pc[N-1:AW+2];
`else
  logic unused_pc_hi;
  assign unused_pc_hi = ^pc[N-1:AW+2];
  assign rd_fault     = 1'b0;
`endif

  // Read word: unloaded or out-of-range words return a NOP of zeros
  always_comb begin
    rd_word = '0;
    if (!rd_fault && bitmap_q[idx]) begin
      rd_word = mem_q[idx];
    end
  end

  // Loads stall fetch acceptance; a held response stalls unless drained
  assign req_ready = !ld_en && (state_q == IDLE || rsp_ready);
  assign accept    = req_valid && req_ready;

  // Loaded bitmap update
  always_comb begin
    bitmap_d = bitmap_q;
    if (ld_en) begin
      bitmap_d[ld_addr] = 1'b1;
    end
  end

  // Next-state and response capture
  always_comb begin
    state_d = state_q;
    instr_d = instr_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = RESP;
          instr_d = rd_word;
          fault_d = rd_fault;
        end
      end
      RESP: begin
        if (accept) begin
          instr_d = rd_word;
          fault_d = rd_fault;
        end else if (rsp_ready) begin
          state_d = IDLE;
          instr_d = '0;
          fault_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Word array is intentionally not reset; the bitmap masks stale data
  always_ff @(posedge clk) begin
    if (ld_en) begin
      mem_q[ld_addr] <= ld_data;
    end
  end

  // Control and response registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= IDLE;
      bitmap_q <= '0;
      instr_q  <= '0;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      bitmap_q <= bitmap_d;
      instr_q  <= instr_d;
      fault_q  <= fault_d;
    end
  end

  assign rsp_valid   = (state_q == RESP);
  assign instruction = instr_q;
  assign fault       = fault_q;

endmodule
